// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: data word, ALU opcode and issue FSM state.
package alu_issue_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word;

  localparam word ZERO_WORD = '0;

  typedef enum logic [3:0] {
    alu_nop  = 4'd0,
    alu_add  = 4'd1,
    alu_sub  = 4'd2,
    alu_and  = 4'd3,
    alu_or   = 4'd4,
    alu_xor  = 4'd5,
    alu_eq   = 4'd6,
    alu_ge_s = 4'd7
  } aluop;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } alu_issue_state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Decode request, ALU operand/result and writeback response signals of the issue stage.
interface alu_issue_if #(
  parameter int RD_W = 5
);
  import alu_issue_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  aluop            req_op_i;
  word             req_data1_i;
  word             req_data2_i;
  logic [RD_W-1:0] req_rd_i;

  aluop            ALU_op_o;
  word             ALU_data1_o;
  word             ALU_data2_o;
  word             ALU_result_i;
  logic            ALU_busy_i;

  logic            rsp_valid_o;
  logic            rsp_ready_i;
  word             rsp_result_o;
  logic [RD_W-1:0] rsp_rd_o;
  logic            rsp_err_o;

  modport master (
    input  req_valid_i, req_op_i, req_data1_i, req_data2_i, req_rd_i,
    input  ALU_result_i, ALU_busy_i, rsp_ready_i,
    output req_ready_o, ALU_op_o, ALU_data1_o, ALU_data2_o,
    output rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_err_o
  );

  modport slave (
    output req_valid_i, req_op_i, req_data1_i, req_data2_i, req_rd_i,
    output ALU_result_i, ALU_busy_i, rsp_ready_i,
    input  req_ready_o, ALU_op_o, ALU_data1_o, ALU_data2_o,
    input  rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_err_o
  );

endinterface

// File: rtl/alu_issue.sv
// Issues one operation at a time to the ALU, waits out busy under a watchdog and
// hands the captured result to writeback.
//   state | meaning
//   IDLE  | no operation in flight, ready for decode
//   EXEC  | operands driven to the ALU, waiting for busy to drop
//   HOLD  | response presented to writeback until accepted
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int BUSY_MAX = 16,
  parameter int RD_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  alu_issue_if.master bus
);

  localparam int              WD_W    = $clog2(BUSY_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(BUSY_MAX - 1);
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(BUSY_MAX);

  alu_issue_state_e state_q, state_d;
  aluop             op_q, op_d;
  word              data1_q, data1_d;
  word              data2_q, data2_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             rsp_valid_q, rsp_valid_d;
  word              rsp_result_q, rsp_result_d;
  logic [RD_W-1:0]  rsp_rd_q, rsp_rd_d;
  logic             rsp_err_q, rsp_err_d;

  logic req_ready;
  logic accept;

  assign req_ready = !flush_i &&
                     ((state_q == IDLE) || ((state_q == HOLD) && bus.rsp_ready_i));
  assign accept    = bus.req_valid_i && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= alu_nop;
      data1_q      <= ZERO_WORD;
      data2_q      <= ZERO_WORD;
      rd_q         <= '0;
      wd_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= ZERO_WORD;
      rsp_rd_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      rd_q         <= rd_d;
      wd_q         <= wd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_rd_q     <= rsp_rd_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    rd_d         = rd_q;
    wd_d         = wd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_rd_d     = rsp_rd_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: ;
      EXEC: begin
        if (!bus.ALU_busy_i || (wd_q == WD_LAST)) begin
          rsp_valid_d  = 1'b1;
          rsp_rd_d     = rd_q;
          rsp_err_d    = bus.ALU_busy_i;
          rsp_result_d = bus.ALU_busy_i ? ZERO_WORD : bus.ALU_result_i;
          state_d      = HOLD;
          op_d         = alu_nop;
          data1_d      = ZERO_WORD;
          data2_d      = ZERO_WORD;
          if (bus.ALU_busy_i) wd_d = WD_SAT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response handshake and a new acceptance can share one edge in HOLD.
    if (accept) begin
      op_d    = bus.req_op_i;
      data1_d = bus.req_data1_i;
      data2_d = bus.req_data2_i;
      rd_d    = bus.req_rd_i;
      wd_d    = '0;
      state_d = EXEC;
    end

    if (flush_i) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
      op_d        = alu_nop;
      data1_d     = ZERO_WORD;
      data2_d     = ZERO_WORD;
      wd_d        = '0;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.ALU_op_o     = op_q;
  assign bus.ALU_data1_o  = data1_q;
  assign bus.ALU_data2_o  = data2_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_result_o = rsp_result_q;
  assign bus.rsp_rd_o     = rsp_rd_q;
  assign bus.rsp_err_o    = rsp_err_q;

  a_valid_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid_q |-> (state_q == HOLD));

  a_no_ready_in_exec: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == EXEC) |-> !req_ready);

  a_alu_stable: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == EXEC) && (state_d == EXEC)) |=>
      ($stable(op_q) && $stable(data1_q) && $stable(data2_q)));

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed scenarios followed by randomized traffic
// with backpressure, busy stalls, watchdog aborts and flushes.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int BUSY_MAX = 4;
  localparam int RD_W     = 5;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic flush_i = 1'b0;

  alu_issue_if #(.RD_W(RD_W)) ifc ();

  alu_issue #(.BUSY_MAX(BUSY_MAX), .RD_W(RD_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    word             result;
    logic [RD_W-1:0] rd;
    logic            err;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        mon_e;
  rsp_t        push_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cur_busy = 0;
  int unsigned acc_busy = 0;
  int unsigned busy_left = 0;
  int          acc_cnt = 0, seen_acc = 0;
  int          kill_cnt = 0, seen_kill = 0;
  bit          r_acc;
  logic [3:0]  r_code;

  function automatic word ref_alu(aluop op, word a, word b);
    case (op)
      alu_add:  return a + b;
      alu_sub:  return a - b;
      alu_and:  return a & b;
      alu_or:   return a | b;
      alu_xor:  return a ^ b;
      alu_eq:   return (a == b) ? 32'd1 : 32'd0;
      alu_ge_s: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural ALU: combinational result, busy for the requested number of cycles.
  always_comb ifc.ALU_result_i = ref_alu(ifc.ALU_op_o, ifc.ALU_data1_o, ifc.ALU_data2_o);

  always @(posedge clk) begin
    #1;
    if (kill_cnt != seen_kill) begin
      seen_kill = kill_cnt;
      busy_left = 0;
    end else if (acc_cnt != seen_acc) begin
      seen_acc  = acc_cnt;
      busy_left = acc_busy;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    ifc.ALU_busy_i = (busy_left > 0);
  end

  // Scoreboard input: expected response computed when a request is accepted.
  always @(negedge clk) begin
    #1;
    if (!rst_n || flush_i) begin
      exp_q.delete();
      kill_cnt++;
    end else if (ifc.req_valid_i && ifc.req_ready_o) begin
      push_e.err    = (cur_busy >= BUSY_MAX);
      push_e.result = push_e.err ? 32'd0
                                 : ref_alu(ifc.req_op_i, ifc.req_data1_i, ifc.req_data2_i);
      push_e.rd     = ifc.req_rd_i;
      exp_q.push_back(push_e);
      acc_busy = cur_busy;
      acc_cnt++;
    end
  end

  // Monitor: every completed writeback handshake is compared against the queue.
  always @(negedge clk) begin
    if (rst_n && ifc.rsp_valid_o && ifc.rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got response result=%0h rd=%0d err=%0b, expected none",
                 ifc.rsp_result_o, ifc.rsp_rd_o, ifc.rsp_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_result", 64'(ifc.rsp_result_o), 64'(mon_e.result));
        chk("rsp_rd",     64'(ifc.rsp_rd_o),     64'(mon_e.rd));
        chk("rsp_err",    64'(ifc.rsp_err_o),    64'(mon_e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(aluop op, word a, word b, logic [RD_W-1:0] rd, int unsigned bz);
    bit acc = 1'b0;
    ifc.req_op_i    = op;
    ifc.req_data1_i = a;
    ifc.req_data2_i = b;
    ifc.req_rd_i    = rd;
    cur_busy        = bz;
    ifc.req_valid_i = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = ifc.req_ready_o;
      step();
    end
    ifc.req_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: request not accepted in 50 cycles, expected acceptance");
    end
  endtask

  task automatic chk_exec(string tag, aluop op, word a, word b);
    chk({tag, "_op"},    64'(ifc.ALU_op_o),    64'(op));
    chk({tag, "_d1"},    64'(ifc.ALU_data1_o), 64'(a));
    chk({tag, "_d2"},    64'(ifc.ALU_data2_o), 64'(b));
    chk({tag, "_ready"}, 64'(ifc.req_ready_o), 64'd0);
    chk({tag, "_valid"}, 64'(ifc.rsp_valid_o), 64'd0);
  endtask

  initial begin
    ifc.req_valid_i = 1'b0;
    ifc.req_op_i    = alu_nop;
    ifc.req_data1_i = '0;
    ifc.req_data2_i = '0;
    ifc.req_rd_i    = '0;
    ifc.rsp_ready_i = 1'b1;

    @(negedge clk);
    chk("rst_ready",  64'(ifc.req_ready_o),  64'd1);
    chk("rst_valid",  64'(ifc.rsp_valid_o),  64'd0);
    chk("rst_op",     64'(ifc.ALU_op_o),     64'(alu_nop));
    chk("rst_d1",     64'(ifc.ALU_data1_o),  64'd0);
    chk("rst_result", 64'(ifc.rsp_result_o), 64'd0);
    chk("rst_err",    64'(ifc.rsp_err_o),    64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic add with one-cycle latency.
    send(alu_add, 32'd5, 32'd7, 5'd3, 0);
    @(negedge clk);
    chk_exec("add_exec", alu_add, 32'd5, 32'd7);
    step();
    @(negedge clk);
    chk("add_latency", 64'(ifc.rsp_valid_o), 64'd1);
    step();
    @(negedge clk);
    chk("add_done_valid", 64'(ifc.rsp_valid_o), 64'd0);
    chk("add_done_op",    64'(ifc.ALU_op_o),    64'(alu_nop));
    step();

    // Busy stall of three cycles.
    send(alu_sub, 32'd10, 32'd3, 5'd9, 3);
    repeat (4) begin
      @(negedge clk);
      chk_exec("stall", alu_sub, 32'd10, 32'd3);
      step();
    end
    @(negedge clk);
    chk("stall_valid", 64'(ifc.rsp_valid_o), 64'd1);
    step();

    // Watchdog abort with busy held past BUSY_MAX.
    send(alu_add, 32'd1, 32'd2, 5'd4, 6);
    repeat (4) begin
      @(negedge clk);
      chk("wd_pending", 64'(ifc.rsp_valid_o), 64'd0);
      step();
    end
    @(negedge clk);
    chk("wd_valid",  64'(ifc.rsp_valid_o),  64'd1);
    chk("wd_err",    64'(ifc.rsp_err_o),    64'd1);
    chk("wd_result", 64'(ifc.rsp_result_o), 64'd0);
    step();

    // Backpressure, then back-to-back acceptance on the handshake edge.
    ifc.rsp_ready_i = 1'b0;
    send(alu_eq, 32'd9, 32'd9, 5'd11, 0);
    step();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid",  64'(ifc.rsp_valid_o),  64'd1);
      chk("bp_result", 64'(ifc.rsp_result_o), 64'd1);
      chk("bp_rd",     64'(ifc.rsp_rd_o),     64'd11);
      step();
    end
    ifc.rsp_ready_i = 1'b1;
    send(alu_ge_s, 32'hFFFF_FFFF, 32'd1, 5'd12, 0);
    @(negedge clk);
    chk("b2b_valid", 64'(ifc.rsp_valid_o), 64'd0);
    chk("b2b_op",    64'(ifc.ALU_op_o),    64'(alu_ge_s));
    step();
    @(negedge clk);
    chk("b2b_rsp", 64'(ifc.rsp_valid_o), 64'd1);
    step();

    // Flush during EXEC.
    send(alu_add, 32'd1, 32'd1, 5'd1, 3);
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_exec_ready", 64'(ifc.req_ready_o), 64'd0);
    step();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_exec_op",    64'(ifc.ALU_op_o),    64'(alu_nop));
    chk("fl_exec_valid", 64'(ifc.rsp_valid_o), 64'd0);
    chk("fl_exec_idle",  64'(ifc.req_ready_o), 64'd1);
    repeat (6) begin
      step();
      @(negedge clk);
      chk("fl_exec_quiet", 64'(ifc.rsp_valid_o), 64'd0);
    end
    step();

    // Flush during HOLD with a competing request.
    ifc.rsp_ready_i = 1'b0;
    send(alu_sub, 32'd8, 32'd2, 5'd2, 0);
    step();
    @(negedge clk);
    chk("fl_hold_valid", 64'(ifc.rsp_valid_o), 64'd1);
    step();
    flush_i         = 1'b1;
    ifc.req_valid_i = 1'b1;
    ifc.req_op_i    = alu_add;
    @(negedge clk);
    chk("fl_hold_ready", 64'(ifc.req_ready_o), 64'd0);
    step();
    flush_i         = 1'b0;
    ifc.req_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_hold_gone", 64'(ifc.rsp_valid_o), 64'd0);
    chk("fl_hold_op",   64'(ifc.ALU_op_o),    64'(alu_nop));
    step();
    ifc.rsp_ready_i = 1'b1;
    repeat (4) step();

    // Asynchronous reset in the middle of EXEC.
    send(alu_add, 32'd3, 32'd4, 5'd5, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_op",     64'(ifc.ALU_op_o),     64'(alu_nop));
    chk("arst_d1",     64'(ifc.ALU_data1_o),  64'd0);
    chk("arst_d2",     64'(ifc.ALU_data2_o),  64'd0);
    chk("arst_ready",  64'(ifc.req_ready_o),  64'd1);
    chk("arst_valid",  64'(ifc.rsp_valid_o),  64'd0);
    chk("arst_result", 64'(ifc.rsp_result_o), 64'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    repeat (8) step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r_acc = ifc.req_valid_i && ifc.req_ready_o;
      step();
      if (!ifc.req_valid_i || r_acc) begin
        r_code = 4'($urandom_range(0, 8));
        if (r_code == 4'd8) r_code = 4'hF;
        ifc.req_op_i    = aluop'(r_code);
        ifc.req_data1_i = ($urandom_range(0, 1) == 0) ? word'($urandom_range(0, 20)) : word'($urandom);
        ifc.req_data2_i = ($urandom_range(0, 3) == 0) ? ifc.req_data1_i : word'($urandom);
        ifc.req_rd_i    = RD_W'($urandom);
        cur_busy        = $urandom_range(0, 5);
        ifc.req_valid_i = ($urandom_range(0, 9) < 7);
      end
      ifc.rsp_ready_i = ($urandom_range(0, 9) < 7);
      flush_i         = ($urandom_range(0, 24) == 0);
    end

    flush_i         = 1'b0;
    ifc.req_valid_i = 1'b0;
    ifc.rsp_ready_i = 1'b1;
    repeat (12) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Execute-stage initiator that sits on the operand/opcode side of the ALU interface. It accepts one operation at a time from decode over a valid/ready handshake, then drives and holds the operands and opcode on the ALU. It waits for the ALU busy flag to drop, captures the result, and presents it to writeback over a second valid/ready handshake. A watchdog aborts operations whose busy never drops, and a flush input discards in-flight work on a pipeline redirect.

Parameters:
BUSY_MAX, 16, maximum number of cycles in EXEC with busy high before the operation is aborted (legal range 1..255).
RD_W, 5, width of the destination-register tag.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; discards the request in flight and any pending response
req_valid_i  in  1  decode presents a request
req_ready_o  out  1  block accepts the request this cycle
req_op_i  in  aluop  requested operation
req_data1_i  in  word  operand 1
req_data2_i  in  word  operand 2
req_rd_i  in  RD_W  destination tag
ALU_op_o  out  aluop  opcode driven to the ALU
ALU_data1_o  out  word  operand 1 driven to the ALU
ALU_data2_o  out  word  operand 2 driven to the ALU
ALU_result_i  in  word  combinational ALU result
ALU_busy_i  in  1  ALU not yet done; result invalid
rsp_valid_o  out  1  result available
rsp_ready_i  in  1  writeback accepts the result
rsp_result_o  out  word  captured result (zero word on error)
rsp_rd_o  out  RD_W  destination tag of the result
rsp_err_o  out  1  operation aborted by the watchdog

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - All output registers are 0: ALU_op_o = alu_nop, ALU_data*_o = zero word, rsp_* = 0.
  - Watchdog counter = 0.
- States: IDLE, EXEC, HOLD.
- req_ready_o (combinational) is high when:
  - state == IDLE, or
  - state == HOLD and rsp_ready_i == 1.
  - It is low whenever flush_i == 1.
- A request is accepted when req_valid_i && req_ready_o at a rising edge. On acceptance:
  - latch op, data1, data2 and rd into the ALU-side registers;
  - clear the watchdog;
  - go to EXEC.
- ALU_op_o and ALU_data*_o are registered. They are stable for the whole of EXEC and return to alu_nop/zero when EXEC is left without a new acceptance.
- EXEC:
  - If ALU_busy_i == 0, capture ALU_result_i into rsp_result_o, set rsp_err_o = 0, set rsp_valid_o = 1, and go to HOLD.
  - Minimum latency: request accepted at edge N, response valid after edge N+1.
  - If ALU_busy_i == 1, increment the watchdog.
  - When the watchdog reaches BUSY_MAX with busy still high: rsp_result_o = zero word, rsp_err_o = 1, rsp_valid_o = 1, go to HOLD.
- HOLD:
  - rsp_* are held stable while rsp_ready_i == 0.
  - On rsp_ready_i == 1, rsp_valid_o drops at the next edge unless a new request is accepted on the same edge. In that case go straight to EXEC, giving back-to-back throughput of one operation per 2 cycles with a non-busy ALU.
- alu_nop and unknown opcodes follow the same path; the ALU returns the zero word.
- flush_i (synchronous, highest priority): at the next edge, go to IDLE, rsp_valid_o = 0, ALU_op_o = alu_nop, watchdog = 0.
  - Any request presented in the same cycle is not accepted.
  - A response handshaking in the same cycle as flush is treated as completed, because writeback saw valid && ready.
- Reset asserted mid-operation: immediate return to the reset values; no response is produced.
- Watchdog width is ceil(log2(BUSY_MAX+1)). It never wraps, because it saturates at BUSY_MAX.
- Assertions:
  - rsp_valid_o implies state == HOLD.
  - ALU_* are stable during EXEC.
  - req_ready_o is never high in EXEC.

Decomposition:
- type_pkg gains alu_issue_state_e (IDLE, EXEC, HOLD).
- word and aluop stay in the existing packages; the zero word comes from the existing defines.
- No sub-module. The watchdog is a few lines inline; a separate counter module is not justified.

Test Plan:
1. Basic add: req add with 5 and 7, ALU_busy_i = 0, rsp_ready_i = 1. Required: rsp_valid_o high 1 cycle after acceptance, rsp_result_o = 12, rsp_err_o = 0, rsp_rd_o matches req_rd_i.
2. Busy stall: ALU_busy_i high for 3 cycles on sub with 10 and 3. Required: ALU operands stable throughout, response after busy drops with result 7, req_ready_o low during EXEC.
3. Watchdog: BUSY_MAX = 4, ALU_busy_i stuck high. Required: after 4 busy cycles rsp_valid_o = 1, rsp_err_o = 1, rsp_result_o = 0.
4. Backpressure and back-to-back: rsp_ready_i low for 5 cycles on an eq with 9 and 9 (result 1). Required: rsp held stable; then ready and a new ge_s request with 0xFFFFFFFF and 1 accepted on the same edge, next result 0.
5. Flush: assert flush_i in EXEC and in HOLD. Required: IDLE next cycle, no response appears, ALU_op_o = alu_nop.
6. Async reset mid-EXEC: drop rst_n between edges. Required: all outputs go to their reset values immediately, without waiting for a clock edge.
